// File: rtl/apb_master_pkg.sv
// Shared definitions for the APB requester: FSM encoding, protection
// attribute constants and the byte-strobe width helper.
package apb_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    localparam logic [2:0] PROT_NORMAL = 3'b000;
    localparam logic [2:0] PROT_PRIV   = 3'b001;

    // One strobe bit per byte lane of the data bus.
    function automatic int strb_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/apb_master_timer.sv
// ACCESS-phase timeout counter. Cleared when a transfer is accepted,
// advanced on every ACCESS cycle without pready, saturates instead of
// wrapping. A TIMEOUT_CYCLES of 0 never expires.
module apb_master_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // One spare bit so the counter can hold TIMEOUT_CYCLES itself.
    localparam int CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count_reg;

    // Saturating wait-cycle counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != '1)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // Expiry fires on the cycle whose increment would reach the limit,
    // so the FSM leaves ACCESS after exactly TIMEOUT_CYCLES idle cycles.
    if (TIMEOUT_CYCLES == 0) begin : g_off
        assign expired = 1'b0;
    end else begin : g_on
        localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);
        assign expired = enable && (count_reg == LIMIT);
    end

endmodule

// File: rtl/apb_master.sv
// APB4 requester: accepts one command at a time, runs a SETUP/ACCESS
// transfer on the bus and presents the result on a response handshake.
module apb_master
    import apb_master_pkg::*;
#(
    parameter int ADDR_WIDTH     = 3,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                              pclk,
    input  logic                              presetn,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic [ADDR_WIDTH-1:0]             cmd_addr,
    input  logic                              cmd_write,
    input  logic [DATA_WIDTH-1:0]             cmd_wdata,
    input  logic [strb_width(DATA_WIDTH)-1:0] cmd_strb,
    input  logic [2:0]                        cmd_prot,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [DATA_WIDTH-1:0]             rsp_rdata,
    output logic                              rsp_slverr,
    output logic                              rsp_timeout,
    output logic [ADDR_WIDTH-1:0]             paddr,
    output logic [2:0]                        pprot,
    output logic                              pwrite,
    output logic [DATA_WIDTH-1:0]             pwdata,
    output logic [strb_width(DATA_WIDTH)-1:0] pstrb,
    output logic                              psel,
    output logic                              penable,
    input  logic                              pready,
    input  logic [DATA_WIDTH-1:0]             prdata,
    input  logic                              pslverr
);

    localparam int STRB_WIDTH = strb_width(DATA_WIDTH);

    apb_state_e state_reg, state_next;

    logic [ADDR_WIDTH-1:0] paddr_reg;
    logic [2:0]            pprot_reg;
    logic                  pwrite_reg;
    logic [DATA_WIDTH-1:0] pwdata_reg;
    logic [STRB_WIDTH-1:0] pstrb_reg;
    logic                  psel_reg;
    logic                  penable_reg;
    logic                  rsp_valid_reg;
    logic [DATA_WIDTH-1:0] rsp_rdata_reg;
    logic                  rsp_slverr_reg;
    logic                  rsp_timeout_reg;

    logic accept;
    logic complete;
    logic abort;
    logic timer_enable;
    logic timer_expired;

    apb_master_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (pclk),
        .rst_n  (presetn),
        .clear  (accept),
        .enable (timer_enable),
        .expired(timer_expired)
    );

    // Next-state decode plus handshake and timer control.
    always_comb begin
        state_next   = state_reg;
        cmd_ready    = 1'b0;
        accept       = 1'b0;
        complete     = 1'b0;
        abort        = 1'b0;
        timer_enable = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept     = 1'b1;
                    state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                // A ready completer takes priority over a same-cycle timeout.
                if (pready) begin
                    complete   = 1'b1;
                    state_next = ST_RESP;
                end else begin
                    timer_enable = 1'b1;
                    if (timer_expired) begin
                        abort      = 1'b1;
                        state_next = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                // Accepting straight out of RESP avoids an IDLE bubble.
                if (rsp_ready) begin
                    cmd_ready = 1'b1;
                    if (cmd_valid) begin
                        accept     = 1'b1;
                        state_next = ST_SETUP;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State, APB request/phase registers and the captured response.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_reg       <= ST_IDLE;
            paddr_reg       <= '0;
            pprot_reg       <= '0;
            pwrite_reg      <= 1'b0;
            pwdata_reg      <= '0;
            pstrb_reg       <= '0;
            psel_reg        <= 1'b0;
            penable_reg     <= 1'b0;
            rsp_valid_reg   <= 1'b0;
            rsp_rdata_reg   <= '0;
            rsp_slverr_reg  <= 1'b0;
            rsp_timeout_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            psel_reg      <= (state_next == ST_SETUP) || (state_next == ST_ACCESS);
            penable_reg   <= (state_next == ST_ACCESS);
            rsp_valid_reg <= (state_next == ST_RESP);
            // Request fields only change on accept, so they hold between transfers.
            if (accept) begin
                paddr_reg  <= cmd_addr;
                pprot_reg  <= cmd_prot;
                pwrite_reg <= cmd_write;
                pwdata_reg <= cmd_write ? cmd_wdata : '0;
                pstrb_reg  <= cmd_write ? cmd_strb : '0;
            end
            if (complete) begin
                rsp_rdata_reg   <= pwrite_reg ? '0 : prdata;
                rsp_slverr_reg  <= pslverr;
                rsp_timeout_reg <= 1'b0;
            end else if (abort) begin
                rsp_rdata_reg   <= '0;
                rsp_slverr_reg  <= 1'b1;
                rsp_timeout_reg <= 1'b1;
            end
        end
    end

    assign paddr       = paddr_reg;
    assign pprot       = pprot_reg;
    assign pwrite      = pwrite_reg;
    assign pwdata      = pwdata_reg;
    assign pstrb       = pstrb_reg;
    assign psel        = psel_reg;
    assign penable     = penable_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_rdata   = rsp_rdata_reg;
    assign rsp_slverr  = rsp_slverr_reg;
    assign rsp_timeout = rsp_timeout_reg;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: a small register-file completer with
// programmable wait states, error and stuck modes, plus a second
// instance with the timeout disabled.
module tb_apb_master;
    import apb_master_pkg::*;

    logic       pclk = 1'b0;
    logic       presetn = 1'b0;

    // Main instance (TIMEOUT_CYCLES = 4)
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_addr = '0;
    logic       cmd_write = 1'b0;
    logic [7:0] cmd_wdata = '0;
    logic [0:0] cmd_strb = '0;
    logic [2:0] cmd_prot = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_rdata;
    logic       rsp_slverr;
    logic       rsp_timeout;
    logic [2:0] paddr;
    logic [2:0] pprot;
    logic       pwrite;
    logic [7:0] pwdata;
    logic [0:0] pstrb;
    logic       psel;
    logic       penable;
    logic       pready;
    logic [7:0] prdata;
    logic       pslverr;

    // Second instance (timeout disabled), completer never ready
    logic       cmd_valid1 = 1'b0;
    logic       cmd_ready1;
    logic       rsp_valid1;
    logic [7:0] rsp_rdata1;
    logic       rsp_slverr1;
    logic       rsp_timeout1;
    logic [2:0] paddr1;
    logic [2:0] pprot1;
    logic       pwrite1;
    logic [7:0] pwdata1;
    logic [0:0] pstrb1;
    logic       psel1;
    logic       penable1;

    // Stub completer controls
    int         stub_wait = 0;
    logic       stub_stuck = 1'b0;
    logic       stub_err = 1'b0;
    logic       stub_use_mem = 1'b1;
    logic [7:0] stub_rdata = '0;
    int         wait_cnt;
    logic [7:0] mem [8];

    int total = 0;
    int bad = 0;

    always #5 pclk = ~pclk;

    apb_master #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .TIMEOUT_CYCLES(4)) dut (
        .pclk(pclk), .presetn(presetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
        .paddr(paddr), .pprot(pprot), .pwrite(pwrite), .pwdata(pwdata),
        .pstrb(pstrb), .psel(psel), .penable(penable),
        .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    apb_master #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .TIMEOUT_CYCLES(0)) dut_nto (
        .pclk(pclk), .presetn(presetn),
        .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_addr(3'd1),
        .cmd_write(1'b0), .cmd_wdata(8'h00), .cmd_strb(1'b0),
        .cmd_prot(PROT_NORMAL),
        .rsp_valid(rsp_valid1), .rsp_ready(1'b1), .rsp_rdata(rsp_rdata1),
        .rsp_slverr(rsp_slverr1), .rsp_timeout(rsp_timeout1),
        .paddr(paddr1), .pprot(pprot1), .pwrite(pwrite1), .pwdata(pwdata1),
        .pstrb(pstrb1), .psel(psel1), .penable(penable1),
        .pready(1'b0), .prdata(8'h00), .pslverr(1'b0)
    );

    assign pready  = psel && penable && !stub_stuck && (wait_cnt >= stub_wait);
    assign prdata  = stub_use_mem ? mem[paddr] : stub_rdata;
    assign pslverr = stub_err;

    always @(posedge pclk) begin
        if (psel && penable && !pready) wait_cnt <= wait_cnt + 1;
        else                            wait_cnt <= 0;
        if (psel && penable && pready && pwrite && !pslverr && pstrb[0])
            mem[paddr] <= pwdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    // Present a command and let the DUT take it on the next edge.
    task automatic issue(input logic wr, input logic [2:0] a, input logic [7:0] d,
                         input logic s, input logic [2:0] p);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_strb  = s;
        cmd_prot  = p;
        step();
        cmd_valid = 1'b0;
    endtask

    // Step until rsp_valid, counting cycles and psel-high observations.
    task automatic wait_rsp(input string tag, output int cycles, output int psel_hi,
                            output int addr_moves);
        logic [2:0] a0;
        cycles = 0;
        psel_hi = 0;
        addr_moves = 0;
        a0 = paddr;
        while (!rsp_valid && cycles < 40) begin
            if (psel) psel_hi++;
            if (paddr !== a0) addr_moves++;
            step();
            cycles++;
        end
        if (!rsp_valid) check({tag, "_rsp_bound"}, 32'(rsp_valid), 32'd1);
    endtask

    int cyc, ph, mv, viol;
    logic [7:0] hold_rdata;

    initial begin
        // Reset
        presetn = 1'b0;
        step();
        step();
        check("rst_psel", 32'(psel), 32'd0);
        check("rst_penable", 32'(penable), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_paddr", 32'(paddr), 32'd0);
        presetn = 1'b1;
        step();

        // 1: write A5 to addr 5, zero wait states, then read it back
        rsp_ready = 1'b0;
        issue(1'b1, 3'd5, 8'hA5, 1'b1, PROT_PRIV);
        check("t1_psel_n1", 32'(psel), 32'd1);
        check("t1_pen_n1", 32'(penable), 32'd0);
        check("t1_fields", {paddr, pprot, pwrite, pwdata, pstrb}, {3'd5, PROT_PRIV, 1'b1, 8'hA5, 1'b1});
        check("t1_cmd_ready_busy", 32'(cmd_ready), 32'd0);
        step();
        check("t1_pen_n2", 32'(penable), 32'd1);
        step();
        check("t1_rsp_n3", 32'(rsp_valid), 32'd1);
        check("t1_psel_resp", 32'(psel), 32'd0);
        check("t1_slverr", 32'(rsp_slverr), 32'd0);
        rsp_ready = 1'b1;
        step();
        check("t1_idle", {rsp_valid, cmd_ready}, 32'b01);
        $display("txn write addr=5 data=a5 done");
        issue(1'b0, 3'd5, 8'hFF, 1'b1, PROT_NORMAL);
        check("t1_rd_pwdata_pstrb", {pwdata, pstrb}, 32'd0);
        wait_rsp("t1_rd", cyc, ph, mv);
        check("t1_rd_latency", cyc, 32'd2);
        check("t1_rd_data", 32'(rsp_rdata), 32'hA5);
        step();
        $display("txn read addr=5 rdata=%0h", rsp_rdata);

        // 2: read with 3 wait states, completer data 3C
        stub_use_mem = 1'b0;
        stub_rdata   = 8'h3C;
        stub_wait    = 3;
        issue(1'b0, 3'd2, 8'h00, 1'b0, PROT_NORMAL);
        wait_rsp("t2", cyc, ph, mv);
        check("t2_latency", cyc, 32'd5);
        check("t2_psel_cycles", ph, 32'd5);
        check("t2_paddr_stable", mv, 32'd0);
        check("t2_rdata", 32'(rsp_rdata), 32'h3C);
        check("t2_slverr", 32'(rsp_slverr), 32'd0);
        step();
        $display("txn read addr=2 waits=3 rdata=%0h", rsp_rdata);
        stub_use_mem = 1'b1;
        stub_wait    = 0;

        // 3: completer error on a write
        stub_err = 1'b1;
        issue(1'b1, 3'd3, 8'h77, 1'b1, PROT_NORMAL);
        wait_rsp("t3", cyc, ph, mv);
        check("t3_err", {rsp_slverr, rsp_timeout, rsp_rdata}, {1'b1, 1'b0, 8'h00});
        step();
        stub_err = 1'b0;
        $display("txn write addr=3 slverr");

        // 4a: completer stuck, 4-cycle timeout
        stub_stuck = 1'b1;
        issue(1'b0, 3'd4, 8'h00, 1'b0, PROT_NORMAL);
        wait_rsp("t4", cyc, ph, mv);
        check("t4_psel_cycles", ph, 32'd5);
        check("t4_psel_dropped", 32'(psel), 32'd0);
        check("t4_timeout", {rsp_slverr, rsp_timeout, rsp_rdata}, {1'b1, 1'b1, 8'h00});
        step();
        stub_stuck = 1'b0;
        $display("txn read addr=4 timeout");

        // 4b: timeout disabled, psel must stay high with no response
        cmd_valid1 = 1'b1;
        step();
        cmd_valid1 = 1'b0;
        viol = 0;
        for (int i = 0; i < 100; i++) begin
            if (!psel1 || rsp_valid1) viol++;
            step();
        end
        check("t4_no_timeout", viol, 32'd0);
        $display("txn read no-timeout instance held 100 cycles");

        // 5: response back-pressure, then back-to-back accepts
        rsp_ready = 1'b0;
        issue(1'b1, 3'd6, 8'h66, 1'b1, PROT_NORMAL);
        wait_rsp("t5", cyc, ph, mv);
        hold_rdata = rsp_rdata;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 3'd6;
        viol = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (!rsp_valid || rsp_slverr || rsp_timeout || rsp_rdata !== hold_rdata
                || cmd_ready || psel) viol++;
        end
        check("t5_hold", viol, 32'd0);
        rsp_ready = 1'b1;
        #1;
        check("t5_cmd_ready_comb", 32'(cmd_ready), 32'd1);
        step();
        check("t5_accept_same_edge", {psel, penable, rsp_valid, pwrite}, 32'b1000);
        cmd_addr = 3'd5;
        step();
        step();
        check("t5_b2b_rdata", 32'(rsp_rdata), 32'h66);
        step();
        check("t5_b2b_psel", {psel, penable, paddr}, {1'b1, 1'b0, 3'd5});
        cmd_valid = 1'b0;
        step();
        step();
        check("t5_b2b2_rdata", 32'(rsp_rdata), 32'hA5);
        step();
        $display("txn back-to-back reads rdata=66,a5");

        // 6: reset during ACCESS, then a clean write/read
        stub_wait = 3;
        issue(1'b0, 3'd5, 8'h00, 1'b0, PROT_NORMAL);
        step();
        presetn = 1'b0;
        step();
        check("t6_abort", {psel, penable, rsp_valid, cmd_ready}, 32'b0001);
        presetn = 1'b1;
        stub_wait = 0;
        viol = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (rsp_valid || psel) viol++;
        end
        check("t6_no_stray", viol, 32'd0);
        issue(1'b1, 3'd2, 8'h5A, 1'b1, PROT_NORMAL);
        wait_rsp("t6_wr", cyc, ph, mv);
        check("t6_wr_ok", {rsp_slverr, rsp_timeout}, 32'd0);
        step();
        issue(1'b0, 3'd2, 8'h00, 1'b0, PROT_NORMAL);
        wait_rsp("t6_rd", cyc, ph, mv);
        check("t6_rd_data", 32'(rsp_rdata), 32'h5A);
        step();
        $display("txn reset mid-access then write/read addr=2 rdata=%0h", rsp_rdata);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
